// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter that snoops the core's data-memory
//   store port. Stores to TX_ADDR queue write_data[7:0] into a small FIFO;
//   a four-state FSM drains the FIFO and serialises each byte LSB first.
//   STAT_ADDR gives a combinational status read path; a store to it with
//   write_data[2]=1 clears the sticky overflow flag.
//
// Ports
//   i_clk_w         in   1   clock, all state on rising edge
//   i_rst_w         in   1   asynchronous active-low reset
//   i_mem_write_w   in   1   core store strobe for the current cycle
//   i_data_addr_w   in   32  core data address
//   i_write_data_w  in   32  core store data
//   o_hit_w         out  1   address decodes to TX_ADDR or STAT_ADDR
//   o_rd_data_w     out  32  {29'b0, ovf, full, busy} at STAT_ADDR, else 0
//   o_tx_w          out  1   serial line, idle high, registered
//   o_busy_w        out  1   FSM active or FIFO non-empty
//   o_dbg_state_w   out  2   FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Handshake: this block has no back-pressure. A store strobe is a one-cycle
// valid with an implicit ready of !full; a store that arrives while full is
// dropped and recorded in the overflow flag.
module mmio_uart_tx #(
    parameter logic [31:0] TX_ADDR      = 32'hFFFF_FF00,
    parameter logic [31:0] STAT_ADDR    = 32'hFFFF_FF04,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        i_clk_w,
    input  logic        i_rst_w,
    input  logic        i_mem_write_w,
    input  logic [31:0] i_data_addr_w,
    input  logic [31:0] i_write_data_w,
    output logic        o_hit_w,
    output logic [31:0] o_rd_data_w,
    output logic        o_tx_w,
    output logic        o_busy_w,
    output logic [1:0]  o_dbg_state_w
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CLK_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             ovf;

    state_t           state, state_n;
    logic [CLK_W-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shift_reg, shift_n;
    logic             tx_reg, tx_n;
    logic             pop;

    logic addr_tx, addr_stat, full, empty, push_req, push, ovf_clr, busy, term;
    logic unused_ok;

    // Address decode and status read path
    assign addr_tx   = (i_data_addr_w == TX_ADDR);
    assign addr_stat = (i_data_addr_w == STAT_ADDR);
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign push_req  = i_mem_write_w && addr_tx;
    assign push      = push_req && !full;
    assign ovf_clr   = i_mem_write_w && addr_stat && i_write_data_w[2];
    assign busy      = (state != S_IDLE) || !empty;
    assign term      = (clk_cnt == CLK_LAST);

    assign o_hit_w       = addr_tx || addr_stat;
    assign o_rd_data_w   = addr_stat ? {29'b0, ovf, full, busy} : 32'b0;
    assign o_tx_w        = tx_reg;
    assign o_busy_w      = busy;
    assign o_dbg_state_w = state;
    assign unused_ok     = ^{i_write_data_w[31:8], i_write_data_w[1:0]};

    // FSM next-state and datapath
    always_comb begin
        state_n   = state;
        tx_n      = tx_reg;
        clk_cnt_n = clk_cnt;
        bit_cnt_n = bit_cnt;
        shift_n   = shift_reg;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                // Uses the pre-edge count, so a byte pushed this edge is
                // only poppable on the next one.
                if (!empty) begin
                    pop       = 1'b1;
                    shift_n   = fifo_mem[rd_ptr];
                    tx_n      = 1'b0;
                    clk_cnt_n = '0;
                    state_n   = S_START;
                end
            end
            S_START: begin
                if (term) begin
                    tx_n      = shift_reg[0];
                    bit_cnt_n = 3'd0;
                    clk_cnt_n = '0;
                    state_n   = S_DATA;
                end else begin
                    clk_cnt_n = clk_cnt + CLK_W'(1);
                end
            end
            S_DATA: begin
                if (term) begin
                    clk_cnt_n = '0;
                    if (bit_cnt == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = S_STOP;
                    end else begin
                        shift_n   = shift_reg >> 1;
                        tx_n      = shift_reg[1];
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CLK_W'(1);
                end
            end
            S_STOP: begin
                if (term) begin
                    clk_cnt_n = '0;
                    tx_n      = 1'b1;
                    state_n   = S_IDLE;
                end else begin
                    clk_cnt_n = clk_cnt + CLK_W'(1);
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = S_IDLE;
            end
        endcase
    end

    // FSM and serialiser registers
    always_ff @(posedge i_clk_w or negedge i_rst_w) begin
        if (!i_rst_w) begin
            state     <= S_IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'd0;
            tx_reg    <= 1'b1;
        end else begin
            state     <= state_n;
            clk_cnt   <= clk_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_n;
            tx_reg    <= tx_n;
        end
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge i_clk_w) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_write_data_w[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge i_clk_w or negedge i_rst_w) begin
        if (!i_rst_w) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Full is judged on the pre-edge count even if a pop lands
            // on the same edge.
            if (push_req && full) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
//   Directed bench for mmio_uart_tx with CLKS_PER_BIT=16, FIFO_DEPTH=4.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, half a cycle away from the active rising edge.
module tb_mmio_uart_tx;

    localparam int          CPB  = 16;
    localparam logic [31:0] TX_A = 32'hFFFF_FF00;
    localparam logic [31:0] ST_A = 32'hFFFF_FF04;

    // Clock / reset and DUT
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        hit;
    logic [31:0] rd_data;
    logic        tx;
    logic        busy;
    logic [1:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .TX_ADDR      (TX_A),
        .STAT_ADDR    (ST_A),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .i_clk_w        (clk),
        .i_rst_w        (rst_n),
        .i_mem_write_w  (mem_write),
        .i_data_addr_w  (addr),
        .i_write_data_w (wdata),
        .o_hit_w        (hit),
        .o_rd_data_w    (rd_data),
        .o_tx_w         (tx),
        .o_busy_w       (busy),
        .o_dbg_state_w  (dbg_state)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: one store captured at the next rising edge; returns #1 after it
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_write = 1'b1;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        addr      = 32'd0;
        wdata     = 32'd0;
    endtask

    // Cycle-exact frame check starting at the current sample point; leaves
    // the bench at the sample point that follows the stop bit.
    task automatic check_frame(input logic [7:0] b, input string name);
        logic exp_bit;
        int   idx;
        for (int i = 0; i < 10 * CPB; i++) begin
            idx = i / CPB;
            if (idx == 0)      exp_bit = 1'b0;
            else if (idx == 9) exp_bit = 1'b1;
            else               exp_bit = b[idx-1];
            vectors++;
            if (tx !== exp_bit) begin
                miscompares++;
                $display("FAIL %s cycle %0d: tx=%b expected %b", name, i, tx, exp_bit);
            end
            @(negedge clk);
        end
    endtask

    // Free-running receiver: finds the start bit, samples mid-bit
    task automatic recv_byte(output logic [7:0] b, output logic ok);
        ok = 1'b0;
        b  = 8'd0;
        for (int w = 0; w < 400 && tx !== 1'b0; w++) @(negedge clk);
        if (tx !== 1'b0) return;
        repeat (CPB / 2) @(negedge clk);
        if (tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) return;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_held: tx=%b busy=%b expected tx=1 busy=0", tx, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        addr = ST_A;
        #1;
        vectors++;
        if (rd_data !== 32'd0 || hit !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_status: rd=%h hit=%b expected rd=0 hit=1", rd_data, hit);
        end
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0 || dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_released: tx=%b busy=%b state=%0d expected 1 0 0", tx, busy, dbg_state);
        end
        addr = 32'd0;
    endtask

    task automatic test_single();
        store(TX_A, 32'h0000_00A5);
        @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_latency: tx=%b busy=%b expected tx=1 busy=1", tx, busy);
        end
        @(negedge clk);
        check_frame(8'hA5, "single_a5");
        vectors++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            miscompares++;
            $display("FAIL single_done: busy=%b tx=%b expected busy=0 tx=1", busy, tx);
        end
    endtask

    task automatic test_fill();
        logic [7:0] got;
        logic [7:0] exp_b;
        logic       ok;
        int         lows;
        exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        fork
            begin
                for (int d = 1; d <= 6; d++) store(TX_A, 32'(d));
                @(negedge clk);
                addr = ST_A;
                #1;
                vectors++;
                if (rd_data !== 32'h7) begin
                    miscompares++;
                    $display("FAIL fill_status: rd=%h expected 00000007", rd_data);
                end
                store(ST_A, 32'h4);
                @(negedge clk);
                addr = ST_A;
                #1;
                vectors++;
                if (rd_data !== 32'h3) begin
                    miscompares++;
                    $display("FAIL fill_ovf_clear: rd=%h expected 00000003", rd_data);
                end
                addr = 32'd0;
            end
            begin
                for (int n = 0; n < 5; n++) begin
                    recv_byte(got, ok);
                    exp_b = exp_q.pop_front();
                    vectors++;
                    if (!ok || got !== exp_b) begin
                        miscompares++;
                        $display("FAIL fill_byte%0d: got %h ok=%b expected %h", n, got, ok, exp_b);
                    end
                end
            end
        join
        lows = 0;
        repeat (3 * CPB) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        vectors++;
        if (lows != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_no_sixth: low cycles=%0d busy=%b expected 0 and 0", lows, busy);
        end
    endtask

    task automatic test_back_to_back();
        store(TX_A, 32'h0000_003C);
        store(TX_A, 32'h0000_00C3);
        @(negedge clk);
        check_frame(8'h3C, "b2b_first");
        vectors++;
        if (tx !== 1'b1 || dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL b2b_gap: tx=%b state=%0d expected tx=1 state=0", tx, dbg_state);
        end
        @(negedge clk);
        check_frame(8'hC3, "b2b_second");
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_decode();
        @(negedge clk);
        mem_write = 1'b1;
        addr      = 32'hFFFF_FF08;
        wdata     = 32'h0000_0055;
        #1;
        vectors++;
        if (hit !== 1'b0 || rd_data !== 32'd0) begin
            miscompares++;
            $display("FAIL decode_ff08: hit=%b rd=%h expected 0 0", hit, rd_data);
        end
        @(negedge clk);
        mem_write = 1'b0;
        addr      = TX_A;
        #1;
        vectors++;
        if (hit !== 1'b1 || rd_data !== 32'd0) begin
            miscompares++;
            $display("FAIL decode_load_ff00: hit=%b rd=%h expected 1 0", hit, rd_data);
        end
        @(negedge clk);
        addr = 32'hFFFF_FF05;
        #1;
        vectors++;
        if (hit !== 1'b0 || rd_data !== 32'd0) begin
            miscompares++;
            $display("FAIL decode_ff05: hit=%b rd=%h expected 0 0", hit, rd_data);
        end
        addr = 32'hFFFF_FE04;
        #1;
        vectors++;
        if (hit !== 1'b0) begin
            miscompares++;
            $display("FAIL decode_fe04: hit=%b expected 0", hit);
        end
        addr = ST_A;
        repeat (4) @(negedge clk);
        vectors++;
        if (hit !== 1'b1 || rd_data !== 32'd0 || tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL decode_no_side_effect: hit=%b rd=%h tx=%b busy=%b expected 1 0 1 0",
                     hit, rd_data, tx, busy);
        end
        addr = 32'd0;
    endtask

    task automatic test_reset_mid();
        int lows;
        store(TX_A, 32'h0000_0037);
        store(TX_A, 32'h0000_0099);
        // 0x37 has bit3=0; bit3 occupies cycles 64..79 after the start edge
        repeat (70) @(posedge clk);
        #3;
        vectors++;
        if (tx !== 1'b0 || dbg_state !== 2'd2) begin
            miscompares++;
            $display("FAIL mid_bit3: tx=%b state=%0d expected tx=0 state=2", tx, dbg_state);
        end
        addr  = ST_A;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0 || dbg_state !== 2'd0 || rd_data !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_async_reset: tx=%b busy=%b state=%0d rd=%h expected 1 0 0 0",
                     tx, busy, dbg_state, rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        addr  = 32'd0;
        lows  = 0;
        repeat (3 * CPB) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        vectors++;
        if (lows != 0) begin
            miscompares++;
            $display("FAIL mid_queue_lost: active cycles=%0d expected 0", lows);
        end
        store(TX_A, 32'h0000_005A);
        @(negedge clk);
        @(negedge clk);
        check_frame(8'h5A, "mid_fresh_5a");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_decode();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
